ex_stage: RTL

Execute stage of the 64-bit pipelined core: takes one decoded instruction per cycle from the ID/EX boundary, forwards operands, derives the 4-bit opcode for `alu_64_bit` and instantiates it, resolves conditional branches, and registers everything into the EX/MEM pipeline register. All outputs are registered. Latency is one cycle. The block honours a downstream stall and squashes the wrong-path instruction after a taken branch.

---
 rtl/ex_stage.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage: execute stage of the 64-bit pipelined core.
//
// Takes one decoded instruction per cycle from the ID/EX boundary, forwards
// operands from EX/MEM and WB, derives the 4-bit ALU opcode, resolves
// conditional branches and registers everything into the EX/MEM register.
// All outputs are registered (one-cycle latency).
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   id_*                       decoded instruction and control from ID/EX
//   wb_reg_write/wb_rd/wb_data write-back forwarding source
//   mem_stall                  hold the EX/MEM register
//   ex_*                       EX/MEM register contents
//   branch_taken/target        redirect request presented from EX/MEM
//
// Also contains alu_64_bit, the ALU used by the stage.
// ---------------------------------------------------------------------------

// 64-bit ALU. Opcode is {funct7_5, funct3} in RISC-V order.
module alu_64_bit (
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [3:0]  op_i,
  output logic [63:0] result_o,
  output logic        zero_o
);

  logic [5:0] shamt;
  assign shamt = b_i[5:0];

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      4'b0000: result_o = a_i + b_i;
      4'b1000: result_o = a_i - b_i;
      4'b0001: result_o = a_i << shamt;
      4'b0010: result_o = {63'd0, $signed(a_i) < $signed(b_i)};
      4'b0011: result_o = {63'd0, a_i < b_i};
      4'b0100: result_o = a_i ^ b_i;
      4'b0101: result_o = a_i >> shamt;
      4'b1101: result_o = $signed(a_i) >>> shamt;
      4'b0110: result_o = a_i | b_i;
      4'b0111: result_o = a_i & b_i;
      default: result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == 64'd0);

endmodule

module ex_stage #(
  parameter int XLEN = 64,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [1:0]      id_alu_op,
  input  logic            id_alu_src,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7_5,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_reg_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            wb_reg_write,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            mem_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_alu_result,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_reg_write,
  output logic            ex_mem_to_reg,
  output logic            ex_zero,
  output logic            ex_illegal,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_target
);

  // EX/MEM pipeline register
  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [XLEN-1:0] store_q, store_d;
  logic [RW-1:0]   rd_q, rd_d;
  logic            memRead_q, memRead_d;
  logic            memWrite_q, memWrite_d;
  logic            regWrite_q, regWrite_d;
  logic            memToReg_q, memToReg_d;
  logic            zero_q, zero_d;
  logic            illegal_q, illegal_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;

  logic [3:0]      aluOp;
  logic            illegal;
  logic [XLEN-1:0] rs1Fwd, rs2Fwd, opB;
  logic [XLEN-1:0] aluResult;
  logic            aluZero;
  logic            exFwdOk;
  logic            branchCond;

  // Opcode derivation; illegal funct combinations fall back to ADD.
  always_comb begin
    aluOp   = 4'b0000;
    illegal = 1'b0;
    case (id_alu_op)
      2'b00: aluOp = 4'b0000;
      2'b01: begin
        case (id_funct3)
          3'b000, 3'b001: aluOp = 4'b1000;
          3'b100, 3'b101: aluOp = 4'b0010;
          3'b110, 3'b111: aluOp = 4'b0011;
          default:        illegal = 1'b1;
        endcase
      end
      2'b10: begin
        if (id_funct7_5 && (id_funct3 != 3'b000) && (id_funct3 != 3'b101))
          illegal = 1'b1;
        else
          aluOp = {id_funct7_5, id_funct3};
      end
      default: aluOp = {id_funct7_5 & (id_funct3 == 3'b101), id_funct3};
    endcase
  end

  // Forwarding: EX/MEM result first (never for loads), then WB, never x0.
  assign exFwdOk = valid_q & regWrite_q & ~memRead_q & (rd_q != '0);

  always_comb begin
    rs1Fwd = id_rs1_data;
    if (exFwdOk && (rd_q == id_rs1))
      rs1Fwd = result_q;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1))
      rs1Fwd = wb_data;
  end

  always_comb begin
    rs2Fwd = id_rs2_data;
    if (exFwdOk && (rd_q == id_rs2))
      rs2Fwd = result_q;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2))
      rs2Fwd = wb_data;
  end

  assign opB = id_alu_src ? id_imm : rs2Fwd;

  alu_64_bit uAlu (
    .a_i      (rs1Fwd),
    .b_i      (opB),
    .op_i     (aluOp),
    .result_o (aluResult),
    .zero_o   (aluZero)
  );

  // SLT/SLTU leave the comparison in bit 0; illegal funct3 never branches.
  always_comb begin
    branchCond = 1'b0;
    if (id_branch && id_valid && !illegal) begin
      case (id_funct3)
        3'b000:         branchCond = aluZero;
        3'b001:         branchCond = ~aluZero;
        3'b100, 3'b110: branchCond = aluResult[0];
        3'b101, 3'b111: branchCond = ~aluResult[0];
        default:        branchCond = 1'b0;
      endcase
    end
  end

  // Next-state: hold on stall, bubble after a taken branch, else capture.
  always_comb begin
    valid_d    = valid_q;
    result_d   = result_q;
    store_d    = store_q;
    rd_d       = rd_q;
    memRead_d  = memRead_q;
    memWrite_d = memWrite_q;
    regWrite_d = regWrite_q;
    memToReg_d = memToReg_q;
    zero_d     = zero_q;
    illegal_d  = illegal_q;
    taken_d    = taken_q;
    target_d   = target_q;
    if (!mem_stall) begin
      result_d = aluResult;
      store_d  = rs2Fwd;
      rd_d     = id_rd;
      zero_d   = aluZero;
      target_d = id_pc + id_imm;
      if (taken_q) begin
        valid_d    = 1'b0;
        memRead_d  = 1'b0;
        memWrite_d = 1'b0;
        regWrite_d = 1'b0;
        memToReg_d = 1'b0;
        illegal_d  = 1'b0;
        taken_d    = 1'b0;
      end else begin
        valid_d    = id_valid;
        memRead_d  = id_mem_read & id_valid;
        memWrite_d = id_mem_write & id_valid;
        regWrite_d = id_reg_write & id_valid;
        memToReg_d = id_mem_to_reg & id_valid;
        illegal_d  = illegal & id_valid;
        taken_d    = branchCond;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      result_q   <= '0;
      store_q    <= '0;
      rd_q       <= '0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      regWrite_q <= 1'b0;
      memToReg_q <= 1'b0;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      result_q   <= result_d;
      store_q    <= store_d;
      rd_q       <= rd_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      regWrite_q <= regWrite_d;
      memToReg_q <= memToReg_d;
      zero_q     <= zero_d;
      illegal_q  <= illegal_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_alu_result = result_q;
  assign ex_store_data = store_q;
  assign ex_rd         = rd_q;
  assign ex_mem_read   = memRead_q;
  assign ex_mem_write  = memWrite_q;
  assign ex_reg_write  = regWrite_q;
  assign ex_mem_to_reg = memToReg_q;
  assign ex_zero       = zero_q;
  assign ex_illegal    = illegal_q;
  assign branch_taken  = taken_q;
  assign branch_target = target_q;

endmodule
